// File: rtl/univ_shift_reg.sv
// univ_shift_reg
//   Universal shift register: parallel load, clear, logical/arithmetic shifts
//   and rotates by a programmable distance, plus an automatic multi-cycle
//   burst of 1-bit shifts driven by a small IDLE/BURST controller.
//
// Ports
//   clk          sole clock, rising edge
//   rst_n        synchronous active-low reset
//   en           execute one operation selected by mode this cycle
//   mode         000 hold, 001 load, 010 shl, 011 shr, 100 rotl, 101 rotr,
//                110 sra, 111 clear
//   data_in      parallel load value
//   ser_in       fill bit for logical-shift vacated positions
//   amt          shift/rotate distance for single operations
//   burst_start  request a burst of 1-bit shifts using mode
//   burst_len    number of 1-bit shifts in the burst
//   out          registered register contents
//   ser_out      registered last bit shifted/rotated out
//   busy         burst in progress
//   done         one-cycle burst-complete pulse
module univ_shift_reg #(
  parameter int WIDTH = 8,
  localparam int AW = $clog2(WIDTH),
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ser_in,
  input  logic [AW-1:0]    amt,
  input  logic             burst_start,
  input  logic [CW-1:0]    burst_len,
  output logic [WIDTH-1:0] out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_ROTL  = 3'b100;
  localparam logic [2:0] M_ROTR  = 3'b101;
  localparam logic [2:0] M_SRA   = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] LSB  = WIDTH'(1);

  logic [0:0]       state;
  logic [2:0]       burst_mode;
  logic [CW-1:0]    count;

  logic [2:0]       op;
  int               k_raw;
  int               k_sh;
  int               k_rot;
  int               ser_pos;
  logic             fill;
  logic [WIDTH-1:0] fill_vec;
  logic [WIDTH-1:0] shift_out;
  logic             shift_ser;
  logic             shift_act;
  logic             burst_ok;

  // Only the shifting modes may start a burst.
  assign burst_ok = burst_start && (mode >= M_SHL) && (mode <= M_SRA);

  // Shared shifter: single ops use mode/amt, the burst uses the latched mode
  // with a distance of one.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    op        = (state == BURST) ? burst_mode : mode;
    k_raw     = (state == BURST) ? 1 : 32'(amt);
    // Shifts saturate at a full vacate; rotates wrap (amt < 2*WIDTH always).
    k_sh      = (k_raw >= WIDTH) ? WIDTH : k_raw;
    k_rot     = (k_raw >= WIDTH) ? k_raw - WIDTH : k_raw;
    fill      = (op == M_SRA) ? out[WIDTH-1] : ser_in;
    fill_vec  = {WIDTH{fill}};
    shift_out = out;
    shift_act = 1'b0;
    ser_pos   = WIDTH;  // out of range selects nothing
    case (op)
      M_SHL: begin
        shift_act = (k_sh != 0);
        shift_out = (out << k_sh) | (fill_vec & ~(ONES << k_sh));
        ser_pos   = WIDTH - k_sh;
      end
      M_SHR, M_SRA: begin
        shift_act = (k_sh != 0);
        shift_out = (out >> k_sh) | (fill_vec & ~(ONES >> k_sh));
        ser_pos   = k_sh - 1;
      end
      M_ROTL: begin
        shift_act = (k_rot != 0);
        shift_out = (out << k_rot) | (out >> (WIDTH - k_rot));
        ser_pos   = WIDTH - k_rot;
      end
      M_ROTR: begin
        shift_act = (k_rot != 0);
        shift_out = (out >> k_rot) | (out << (WIDTH - k_rot));
        ser_pos   = k_rot - 1;
      end
      default: ;
    endcase
    shift_ser = |(out & (LSB << ser_pos));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out        <= '0;
      ser_out    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      state      <= IDLE;
      count      <= '0;
      burst_mode <= M_HOLD;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (burst_ok) begin
            // Accept edge performs no shift; a zero-length burst just
            // completes immediately.
            if (burst_len == '0) begin
              done <= 1'b1;
            end else begin
              state      <= BURST;
              busy       <= 1'b1;
              burst_mode <= mode;
              count      <= burst_len;
            end
          end else if (en) begin
            case (mode)
              M_LOAD:  out <= data_in;
              M_CLEAR: out <= '0;
              M_HOLD:  ;
              default: begin
                if (shift_act) begin
                  out     <= shift_out;
                  ser_out <= shift_ser;
                end
              end
            endcase
          end
        end
        BURST: begin
          out     <= shift_out;
          ser_out <= shift_ser;
          count   <= count - CW'(1);
          if (count == CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg
//   Directed-vector bench for univ_shift_reg (WIDTH = 8). Inputs change 1 ns
//   after the rising edge; outputs are sampled at the same point, i.e. after
//   the edge that produced them.
module tb_univ_shift_reg;

  localparam logic [2:0] M_HOLD  = 3'b000;
  localparam logic [2:0] M_LOAD  = 3'b001;
  localparam logic [2:0] M_SHL   = 3'b010;
  localparam logic [2:0] M_SHR   = 3'b011;
  localparam logic [2:0] M_ROTL  = 3'b100;
  localparam logic [2:0] M_ROTR  = 3'b101;
  localparam logic [2:0] M_SRA   = 3'b110;
  localparam logic [2:0] M_CLEAR = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [2:0] mode;
  logic [7:0] data_in;
  logic       ser_in;
  logic [2:0] amt;
  logic       burst_start;
  logic [3:0] burst_len;
  logic [7:0] out;
  logic       ser_out;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  univ_shift_reg #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .data_in    (data_in),
    .ser_in     (ser_in),
    .amt        (amt),
    .burst_start(burst_start),
    .burst_len  (burst_len),
    .out        (out),
    .ser_out    (ser_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One single-cycle operation.
  task automatic do_op(input logic [2:0] m, input logic [2:0] a, input logic s,
                       input logic [7:0] d);
    en = 1'b1; mode = m; amt = a; ser_in = s; data_in = d;
    tick();
    en = 1'b0;
  endtask

  task automatic start_burst(input logic [2:0] m, input logic [3:0] n);
    burst_start = 1'b1; mode = m; burst_len = n;
    tick();
    burst_start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = M_HOLD; data_in = '0; ser_in = 1'b0;
    amt = '0; burst_start = 1'b0; burst_len = '0;
    tick(); tick();
    check("rst out", out, 8'h00);
    check("rst ser_out", ser_out, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    rst_n = 1'b1;

    do_op(M_LOAD, 3'd0, 1'b0, 8'hAA);
    check("load AA", out, 8'hAA);
    do_op(M_SHL, 3'd1, 1'b0, 8'h00);
    check("shl1 out", out, 8'h54);
    check("shl1 ser", ser_out, 1'b1);
    do_op(M_SHR, 3'd3, 1'b1, 8'h00);
    check("shr3 out", out, 8'hEA);
    check("shr3 ser", ser_out, 1'b1);

    do_op(M_LOAD, 3'd0, 1'b0, 8'hA5);
    do_op(M_ROTL, 3'd4, 1'b1, 8'h00);
    check("rotl4 out", out, 8'h5A);
    check("rotl4 ser", ser_out, 1'b0);

    do_op(M_LOAD, 3'd0, 1'b0, 8'h90);
    do_op(M_SRA, 3'd2, 1'b0, 8'h00);
    check("sra2 out", out, 8'hE4);
    check("sra2 ser", ser_out, 1'b0);

    // amt 0 and load leave ser_out alone.
    do_op(M_LOAD, 3'd0, 1'b0, 8'h01);
    do_op(M_SHR, 3'd1, 1'b0, 8'h00);
    check("shr1 out", out, 8'h00);
    check("shr1 ser", ser_out, 1'b1);
    do_op(M_SHL, 3'd0, 1'b1, 8'h00);
    check("shl0 out", out, 8'h00);
    check("shl0 ser", ser_out, 1'b1);
    do_op(M_LOAD, 3'd0, 1'b0, 8'h3C);
    check("load 3C", out, 8'h3C);
    check("load keeps ser", ser_out, 1'b1);
    do_op(M_ROTR, 3'd7, 1'b0, 8'h00);
    check("rotr7 out", out, 8'h78);
    check("rotr7 ser", ser_out, 1'b0);
    do_op(M_SHL, 3'd7, 1'b1, 8'h00);
    check("shl7 out", out, 8'h7F);
    check("shl7 ser", ser_out, 1'b0);
    do_op(M_HOLD, 3'd3, 1'b1, 8'hFF);
    check("hold out", out, 8'h7F);
    do_op(M_CLEAR, 3'd0, 1'b0, 8'hFF);
    check("clear out", out, 8'h00);

    // burst_start with a non-shift mode is ignored.
    start_burst(M_HOLD, 4'd3);
    check("ign hold busy", busy, 1'b0);
    check("ign hold done", done, 1'b0);
    start_burst(M_CLEAR, 4'd3);
    check("ign clear busy", busy, 1'b0);
    check("ign clear out", out, 8'h00);

    // Burst rotr x3 from 0x81; accepted burst outranks en.
    do_op(M_LOAD, 3'd0, 1'b0, 8'h81);
    en = 1'b1; amt = 3'd2;
    start_burst(M_ROTR, 4'd3);
    check("acc busy", busy, 1'b1);
    check("acc out", out, 8'h81);
    // Everything below is ignored while busy.
    en = 1'b1; burst_start = 1'b1; mode = M_SHL; amt = 3'd1; data_in = 8'hFF;
    tick();
    check("b1 out", out, 8'hC0);
    check("b1 ser", ser_out, 1'b1);
    check("b1 busy", busy, 1'b1);
    check("b1 done", done, 1'b0);
    tick();
    check("b2 out", out, 8'h60);
    check("b2 ser", ser_out, 1'b0);
    check("b2 busy", busy, 1'b1);
    tick();
    burst_start = 1'b0; en = 1'b0;
    check("b3 out", out, 8'h30);
    check("b3 busy", busy, 1'b0);
    check("b3 done", done, 1'b1);
    // A new op is accepted while done is high.
    do_op(M_LOAD, 3'd0, 1'b0, 8'h11);
    check("post done out", out, 8'h11);
    check("post done done", done, 1'b0);

    // Reset after the second shift of a burst.
    do_op(M_LOAD, 3'd0, 1'b0, 8'h81);
    start_burst(M_ROTR, 4'd3);
    tick(); tick();
    check("mid out", out, 8'h60);
    check("mid busy", busy, 1'b1);
    rst_n = 1'b0;
    tick();
    check("mrst out", out, 8'h00);
    check("mrst busy", busy, 1'b0);
    check("mrst done", done, 1'b0);
    check("mrst ser", ser_out, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mrst no done", done, 1'b0);
      check("mrst no busy", busy, 1'b0);
    end

    // Zero-length burst.
    do_op(M_LOAD, 3'd0, 1'b0, 8'h5A);
    start_burst(M_SHL, 4'd0);
    check("len0 done", done, 1'b1);
    check("len0 busy", busy, 1'b0);
    check("len0 out", out, 8'h5A);
    tick();
    check("len0 done end", done, 1'b0);
    check("len0 busy end", busy, 1'b0);
    check("len0 out end", out, 8'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning register width in bits (legal >= 2).
REQ-002 SHALL derive local parameters AW = $clog2(WIDTH) (shift-amount width) and CW = $clog2(WIDTH+1) (burst-length width).
REQ-003 SHALL have port clk  input  1  meaning sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning synchronous active-low reset.
REQ-005 SHALL have port en  input  1  meaning execute a single operation selected by mode this cycle.
REQ-006 SHALL have port mode  input  3  meaning operation select: 000 hold, 001 load, 010 shl logical, 011 shr logical, 100 rotl, 101 rotr, 110 sra, 111 clear.
REQ-007 SHALL have port data_in  input  WIDTH  meaning parallel load value.
REQ-008 SHALL have port ser_in  input  1  meaning fill bit for logical-shift vacated positions.
REQ-009 SHALL have port amt  input  AW  meaning shift or rotate distance for single operations.
REQ-010 SHALL have port burst_start  input  1  meaning request an automatic multi-cycle 1-bit shift burst.
REQ-011 SHALL have port burst_len  input  CW  meaning number of 1-bit shifts in the burst.
REQ-012 SHALL have port out  output  WIDTH  meaning registered register contents.
REQ-013 SHALL have port ser_out  output  1  meaning registered last bit shifted or rotated out.
REQ-014 SHALL have ports busy  output  1  (burst in progress) and done  output  1  (one-cycle burst-complete pulse), both registered.

Function
REQ-015 SHALL, on a single op (en=1, IDLE, no accepted burst_start): load out=data_in; clear out=0; hold no change.
REQ-016 SHALL for shl/shr shift by amt, filling every vacated bit with ser_in.
REQ-017 SHALL rotate rotl/rotr by amt mod WIDTH, and for sra fill vacated bits with the old out[WIDTH-1].
REQ-018 SHALL treat amt >= WIDTH (non-power-of-two WIDTH) as full vacate: logical gives all ser_in, sra all sign.
REQ-019 SHALL set ser_out to the last bit leaving the register: shl out[WIDTH-k], shr/sra/rotr out[k-1], rotl out[WIDTH-k], with k = amt, clamped to WIDTH for shifts and taken mod WIDTH for rotates.
REQ-020 SHALL leave out and ser_out unchanged when k = 0, and on hold, load and clear.
REQ-021 SHALL implement FSM states IDLE and BURST.
REQ-022 SHALL accept burst_start only in IDLE with mode in 010..110; otherwise ignore it with no state change and no done.
REQ-023 SHALL, on acceptance with burst_len = N > 0, latch mode and N, enter BURST and set busy; the accept edge performs no shift.
REQ-024 SHALL in BURST perform one 1-bit shift per edge using the latched mode, updating ser_out per REQ-019 with k = 1.
REQ-025 SHALL, on the edge of the Nth shift, return to IDLE, clear busy and set done high for exactly one cycle.
REQ-026 SHALL, when N = 0 is accepted, stay IDLE with out unchanged and pulse done on the next cycle without asserting busy.
REQ-027 SHALL give burst_start priority over en in the same cycle, and ignore en, burst_start, mode and amt while BURST.
REQ-028 SHALL accept a new burst_start or en in the cycle done is high.

Reset
REQ-029 SHALL, on any edge with rst_n=0, set out=0, ser_out=0, busy=0, done=0, state IDLE and count 0, overriding all other inputs including mid-burst.

Verification
REQ-030 SHALL cover load and shl: reset -> out 0x00; load 0xAA -> 0xAA; shl amt 1, ser_in 0 -> out 0x54, ser_out 1.
REQ-031 SHALL cover shr with fill: from 0x54, shr amt 3, ser_in 1 -> out 0xEA, ser_out 1.
REQ-032 SHALL cover rotate and sra: 0xA5 rotl amt 4 -> 0x5A; 0x90 sra amt 2 -> 0xE4, ser_out 0.
REQ-033 SHALL cover a burst: out 0x81, rotr, burst_len 3 -> busy high 3 cycles, then out 0x30, done 1 cycle; en pulses during busy have no effect.
REQ-034 SHALL cover reset mid-burst: rst_n=0 after the 2nd shift -> out 0x00, busy 0, done never asserted.
REQ-035 SHALL cover burst_len 0: accepted -> done pulses next cycle, busy stays 0, out unchanged.
